// File: rtl/source_marker_overlay.sv
// Rescales projected sound-source coordinates to display pixels with one shared restoring
// divider, latches them per frame and draws a square outline marker on the video stream.
module source_marker_overlay #(
    parameter int          H_ACT       = 640,
    parameter int          V_ACT       = 480,
    parameter int          SRC_W       = 4000,
    parameter int          SRC_H       = 2900,
    parameter int          MARK_R      = 8,
    parameter logic [23:0] MARK_COLOR  = 24'hFF0000,
    parameter int          HOLD_FRAMES = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        coord_valid,
    output logic        coord_ready,
    input  logic [15:0] x_2d,
    input  logic [15:0] y_2d,
    input  logic        marker_en,
    input  logic        vs_in,
    input  logic        hs_in,
    input  logic        de_in,
    input  logic [23:0] rgb_in,
    output logic        vs_out,
    output logic        hs_out,
    output logic        de_out,
    output logic [23:0] rgb_out
);

    localparam int DIV_W   = 24;
    localparam int SRC_MAX = (SRC_W > SRC_H) ? SRC_W : SRC_H;
    localparam int REM_W   = $clog2(SRC_MAX) + 1;
    localparam int CNT_W   = 12;
    localparam int AGE_W   = $clog2(HOLD_FRAMES + 1);

    localparam logic signed [CNT_W-1:0] R_OUT = CNT_W'(MARK_R);
    localparam logic signed [CNT_W-1:0] R_IN  = CNT_W'(MARK_R - 1);

    typedef enum logic [1:0] {IDLE, DIV_X, DIV_Y, DONE} state_t;

    function automatic logic [15:0] clamp_src(input logic [15:0] v, input int lim);
        return (v >= 16'(lim)) ? 16'(lim - 1) : v;
    endfunction

    function automatic logic [CNT_W-1:0] clamp_q(input logic [DIV_W-1:0] q, input int lim);
        return (q >= DIV_W'(lim)) ? CNT_W'(lim - 1) : q[CNT_W-1:0];
    endfunction

    function automatic logic signed [CNT_W-1:0] abs_s(input logic signed [CNT_W-1:0] v);
        return (v < 0) ? -v : v;
    endfunction

    state_t state, state_nxt;

    logic                   accept;
    logic                   done_wr;
    logic [4:0]             div_cnt;
    logic                   div_last;
    logic [DIV_W-1:0]       div_q;
    logic [REM_W-2:0]       div_r;
    logic [REM_W-1:0]       div_d;
    logic [REM_W-1:0]       rem_sh;
    logic [REM_W-2:0]       rem_diff;
    logic [REM_W-2:0]       rem_nxt;
    logic                   rem_ge;
    logic [DIV_W-1:0]       q_nxt;
    logic [15:0]            y_hold;
    logic [CNT_W-1:0]       quot_x;
    logic [CNT_W-1:0]       quot_y;

    logic [CNT_W-1:0]       pend_x;
    logic [CNT_W-1:0]       pend_y;
    logic                   pend_valid;
    logic [CNT_W-1:0]       mark_x;
    logic [CNT_W-1:0]       mark_y;
    logic                   mark_valid;
    logic [AGE_W-1:0]       age;

    logic                   vs_d;
    logic                   de_d;
    logic                   vs_rise;
    logic                   de_fall;
    logic [CNT_W-1:0]       h_cnt;
    logic [CNT_W-1:0]       v_cnt;
    logic signed [CNT_W-1:0] dx;
    logic signed [CNT_W-1:0] dy;
    logic                   draw;

    logic                   vs_p1;
    logic                   hs_p1;
    logic                   de_p1;
    logic [23:0]            rgb_p1;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (coord_valid) state_nxt = DIV_X;
            DIV_X:   if (div_last)    state_nxt = DIV_Y;
            DIV_Y:   if (div_last)    state_nxt = DONE;
            DONE:                     state_nxt = IDLE;
            default:                  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        coord_ready = (state == IDLE);
        accept      = coord_ready && coord_valid;
        done_wr     = (state == DONE);
    end

    // One restoring step per clock; the divisor follows the axis being divided.
    always_comb begin
        div_d    = (state == DIV_Y) ? REM_W'(SRC_H) : REM_W'(SRC_W);
        rem_sh   = {div_r, div_q[DIV_W-1]};
        rem_ge   = (rem_sh >= div_d);
        rem_diff = rem_sh[REM_W-2:0] - div_d[REM_W-2:0];
        rem_nxt  = rem_ge ? rem_diff : rem_sh[REM_W-2:0];
        q_nxt    = {div_q[DIV_W-2:0], rem_ge};
        div_last = (div_cnt == 5'(DIV_W - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (state == DIV_X || state == DIV_Y) begin
            div_cnt <= div_last ? '0 : div_cnt + 1'b1;
        end else begin
            div_cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            div_q  <= DIV_W'(clamp_src(x_2d, SRC_W)) * DIV_W'(H_ACT);
            div_r  <= '0;
            y_hold <= clamp_src(y_2d, SRC_H);
        end else if (state == DIV_X && div_last) begin
            quot_x <= clamp_q(q_nxt, H_ACT);
            div_q  <= DIV_W'(y_hold) * DIV_W'(V_ACT);
            div_r  <= '0;
        end else if (state == DIV_Y && div_last) begin
            quot_y <= clamp_q(q_nxt, V_ACT);
        end else if (state == DIV_X || state == DIV_Y) begin
            div_q <= q_nxt;
            div_r <= rem_nxt;
        end
    end

    always_comb begin
        vs_rise = vs_in && !vs_d;
        de_fall = !de_in && de_d;
    end

    // Frame latch reads the old pending value before a same-edge DONE overwrites it.
    always_ff @(posedge clk) begin
        if (rst) begin
            vs_d       <= 1'b0;
            de_d       <= 1'b0;
            h_cnt      <= '0;
            v_cnt      <= '0;
            pend_valid <= 1'b0;
            mark_valid <= 1'b0;
            age        <= '0;
        end else begin
            vs_d <= vs_in;
            de_d <= de_in;
            if (de_in)        h_cnt <= h_cnt + 1'b1;
            else if (de_fall) h_cnt <= '0;
            if (vs_rise)      v_cnt <= '0;
            else if (de_fall) v_cnt <= v_cnt + 1'b1;
            if (vs_rise) begin
                if (pend_valid) begin
                    mark_valid <= 1'b1;
                    age        <= '0;
                    pend_valid <= 1'b0;
                end else if (age < AGE_W'(HOLD_FRAMES)) begin
                    age <= age + 1'b1;
                    if (age == AGE_W'(HOLD_FRAMES - 1)) mark_valid <= 1'b0;
                end
            end
            if (done_wr) pend_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (vs_rise && pend_valid) begin
            mark_x <= pend_x;
            mark_y <= pend_y;
        end
        if (done_wr) begin
            pend_x <= quot_x;
            pend_y <= quot_y;
        end
    end

    always_comb begin
        dx   = abs_s($signed(h_cnt) - $signed(mark_x));
        dy   = abs_s($signed(v_cnt) - $signed(mark_y));
        draw = marker_en && mark_valid && de_in && (dx <= R_OUT) && (dy <= R_OUT) &&
               ((dx >= R_IN) || (dy >= R_IN));
    end

    // Stage p1: registered video with the overlay applied.
    always_ff @(posedge clk) begin
        if (rst) begin
            vs_p1  <= 1'b0;
            hs_p1  <= 1'b0;
            de_p1  <= 1'b0;
            rgb_p1 <= '0;
        end else begin
            vs_p1  <= vs_in;
            hs_p1  <= hs_in;
            de_p1  <= de_in;
            rgb_p1 <= draw ? MARK_COLOR : rgb_in;
        end
    end

    assign vs_out  = vs_p1;
    assign hs_out  = hs_p1;
    assign de_out  = de_p1;
    assign rgb_out = rgb_p1;

endmodule

// File: tb/tb_source_marker_overlay.sv
// Directed bench for source_marker_overlay: table of coordinate/pixel probes plus
// hand-written handshake, collision, persistence and reset sequences.
module tb_source_marker_overlay;

    localparam logic [23:0] RED = 24'hFF0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        coord_valid;
    logic        coord_ready;
    logic [15:0] x_2d;
    logic [15:0] y_2d;
    logic        marker_en;
    logic        vs_in, hs_in, de_in;
    logic [23:0] rgb_in;
    logic        vs_out, hs_out, de_out;
    logic [23:0] rgb_out;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [23:0] line_buf [0:639];
    logic        rdy_hist [0:159];
    int          acc_edges[$];
    logic        rb;

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        int          ph;
        int          pv;
        bit          mark;
    } vec_t;

    vec_t vecs[21];

    always #5 clk = ~clk;

    source_marker_overlay dut (
        .clk(clk), .rst(rst), .coord_valid(coord_valid), .coord_ready(coord_ready),
        .x_2d(x_2d), .y_2d(y_2d), .marker_en(marker_en),
        .vs_in(vs_in), .hs_in(hs_in), .de_in(de_in), .rgb_in(rgb_in),
        .vs_out(vs_out), .hs_out(hs_out), .de_out(de_out), .rgb_out(rgb_out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] pix(input int h, input int v);
        return {4'hA, 8'(v), 12'(h)};
    endfunction

    task automatic set_vid(input logic vs, input logic hs, input logic de, input logic [23:0] rgb);
        vs_in = vs; hs_in = hs; de_in = de; rgb_in = rgb;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (!rst) check("sync_dly", {29'd0, vs_out, hs_out, de_out}, {29'd0, vs_in, hs_in, de_in});
    endtask

    task automatic run_frame(input int pv, input int plen, input bit do_vs);
        if (do_vs) begin
            set_vid(1'b1, 1'b0, 1'b0, 24'h0); tick(); tick();
        end
        set_vid(1'b0, 1'b0, 1'b0, 24'h0); tick();
        for (int l = 0; l < pv; l++) begin
            set_vid(1'b0, 1'b0, 1'b1, pix(0, l)); tick();
            set_vid(1'b0, 1'b1, 1'b0, pix(1, l)); tick();
        end
        for (int h = 0; h < plen; h++) begin
            set_vid(1'b0, 1'b0, 1'b1, pix(h, pv)); tick();
            line_buf[h] = rgb_out;
        end
        set_vid(1'b0, 1'b1, 1'b0, 24'h5A5A5A); tick();
        check("blank_pass", rgb_out, 24'h5A5A5A);
    endtask

    task automatic load_coord(input logic [15:0] x, input logic [15:0] y);
        bit acc;
        acc = 1'b0;
        set_vid(1'b0, 1'b0, 1'b0, 24'h0);
        x_2d = x; y_2d = y; coord_valid = 1'b1;
        for (int i = 0; i < 100 && !acc; i++) begin
            acc = coord_ready;
            tick();
        end
        coord_valid = 1'b0;
        check("load_accept", {31'd0, acc}, 32'd1);
        for (int i = 0; i < 60 && !coord_ready; i++) tick();
        check("load_done", {31'd0, coord_ready}, 32'd1);
    endtask

    initial begin
        #950us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{16'd2000,  16'd1450,  312, 240, 1'b1};
        vecs[1]  = '{16'd2000,  16'd1450,  328, 240, 1'b1};
        vecs[2]  = '{16'd2000,  16'd1450,  313, 240, 1'b1};
        vecs[3]  = '{16'd2000,  16'd1450,  327, 240, 1'b1};
        vecs[4]  = '{16'd2000,  16'd1450,  320, 240, 1'b0};
        vecs[5]  = '{16'd2000,  16'd1450,  311, 240, 1'b0};
        vecs[6]  = '{16'd2000,  16'd1450,  320, 232, 1'b1};
        vecs[7]  = '{16'd2000,  16'd1450,  315, 233, 1'b1};
        vecs[8]  = '{16'd2000,  16'd1450,  315, 234, 1'b0};
        vecs[9]  = '{16'd2000,  16'd1450,  320, 231, 1'b0};
        vecs[10] = '{16'd65500, 16'd0,     631, 0,   1'b1};
        vecs[11] = '{16'd65500, 16'd0,     633, 0,   1'b0};
        vecs[12] = '{16'd65500, 16'd0,     635, 8,   1'b1};
        vecs[13] = '{16'd65500, 16'd0,     630, 8,   1'b0};
        vecs[14] = '{16'd65500, 16'd0,     635, 9,   1'b0};
        vecs[15] = '{16'd65500, 16'd0,     639, 7,   1'b1};
        vecs[16] = '{16'd0,     16'd65535, 8,   471, 1'b1};
        vecs[17] = '{16'd0,     16'd65535, 7,   479, 1'b1};
        vecs[18] = '{16'd0,     16'd65535, 0,   479, 1'b0};
        vecs[19] = '{16'd1000,  16'd1450,  152, 240, 1'b1};
        vecs[20] = '{16'd1000,  16'd1450,  160, 247, 1'b1};

        // Reset with busy inputs: outputs must stay zero, ready high.
        rst = 1'b1; coord_valid = 1'b0; x_2d = '0; y_2d = '0; marker_en = 1'b1;
        set_vid(1'b1, 1'b1, 1'b1, 24'h123456);
        tick(); tick(); tick();
        check("rst_rgb", rgb_out, 24'h0);
        check("rst_sync", {29'd0, vs_out, hs_out, de_out}, 32'd0);
        check("rst_ready", {31'd0, coord_ready}, 32'd1);
        rst = 1'b0;
        set_vid(1'b0, 1'b0, 1'b0, 24'h0);
        tick();
        check("ready_after_rst", {31'd0, coord_ready}, 32'd1);

        // No coordinate yet: nothing drawn.
        run_frame(240, 313, 1'b1);
        check("no_coord_yet", line_buf[312], pix(312, 240));

        // Back-to-back accepts with coord_valid held high.
        x_2d = 16'd2000; y_2d = 16'd1450; coord_valid = 1'b1;
        for (int e = 0; e < 160; e++) begin
            rb = coord_ready;
            tick();
            rdy_hist[e] = coord_ready;
            if (rb) acc_edges.push_back(e);
        end
        coord_valid = 1'b0;
        check("hs_accept_count", acc_edges.size(), 32'd4);
        if (acc_edges.size() > 0) check("hs_first_accept", acc_edges[0], 32'd0);
        for (int k = 1; k < acc_edges.size(); k++)
            check("hs_spacing", acc_edges[k] - acc_edges[k-1], 32'd50);
        check("hs_busy_e0", {31'd0, rdy_hist[0]}, 32'd0);
        check("hs_busy_e48", {31'd0, rdy_hist[48]}, 32'd0);
        check("hs_ready_e49", {31'd0, rdy_hist[49]}, 32'd1);
        for (int i = 0; i < 60 && !coord_ready; i++) tick();
        check("hs_drain", {31'd0, coord_ready}, 32'd1);

        // Table of coordinate / pixel probes.
        for (int i = 0; i < 21; i++) begin
            if (i == 0 || vecs[i].x != vecs[i-1].x || vecs[i].y != vecs[i-1].y)
                load_coord(vecs[i].x, vecs[i].y);
            run_frame(vecs[i].pv, vecs[i].ph + 1, 1'b1);
            check($sformatf("vec%0d_px(%0d,%0d)", i, vecs[i].ph, vecs[i].pv),
                  line_buf[vecs[i].ph], vecs[i].mark ? RED : pix(vecs[i].ph, vecs[i].pv));
        end

        // Global enable off: pure pass-through, then back on.
        marker_en = 1'b0;
        run_frame(240, 161, 1'b1);
        check("en_off_152", line_buf[152], pix(152, 240));
        check("en_off_153", line_buf[153], pix(153, 240));
        marker_en = 1'b1;
        run_frame(240, 161, 1'b1);
        check("en_on_152", line_buf[152], RED);

        // DONE write on the same edge as vs_in rise, nothing pending before.
        set_vid(1'b0, 1'b0, 1'b0, 24'h0);
        x_2d = 16'd2000; y_2d = 16'd1450; coord_valid = 1'b1;
        for (int i = 0; i < 100 && !coord_ready; i++) tick();
        tick();
        coord_valid = 1'b0;
        for (int i = 0; i < 48; i++) tick();
        set_vid(1'b1, 1'b0, 1'b0, 24'h0);
        tick();
        check("coll_ready", {31'd0, coord_ready}, 32'd1);
        run_frame(240, 329, 1'b0);
        check("coll_old_kept", line_buf[152], RED);
        check("coll_new_hidden", line_buf[312], pix(312, 240));
        run_frame(240, 329, 1'b1);
        check("coll_new_shown", line_buf[312], RED);
        check("coll_old_gone", line_buf[152], pix(152, 240));

        // Persistence: frame 0 latches, visible through frame 29.
        load_coord(16'd2000, 16'd1450);
        for (int f = 0; f < 32; f++) begin
            run_frame(240, 313, 1'b1);
            check($sformatf("persist_f%0d", f), line_buf[312], (f <= 29) ? RED : pix(312, 240));
        end

        // Reset in the middle of the y division.
        set_vid(1'b0, 1'b0, 1'b0, 24'h0);
        x_2d = 16'd2000; y_2d = 16'd1450; coord_valid = 1'b1;
        for (int i = 0; i < 100 && !coord_ready; i++) tick();
        tick();
        coord_valid = 1'b0;
        for (int i = 0; i < 30; i++) tick();
        check("mid_div_busy", {31'd0, coord_ready}, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_ready", {31'd0, coord_ready}, 32'd1);
        for (int i = 0; i < 60; i++) tick();
        run_frame(240, 329, 1'b1);
        check("rst_mid_nomark_312", line_buf[312], pix(312, 240));
        check("rst_mid_nomark_328", line_buf[328], pix(328, 240));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/source_marker_overlay.md
# source_marker_overlay

Downstream of the 3D→2D projection stage. Takes the sound-source image coordinate (`x_2d`, `y_2d`, in projection units spanning SRC_W × SRC_H) and rescales it to display pixels with a shared sequential divider. It latches the result at frame boundaries and draws a square outline marker onto the passing RGB video stream, delayed by one clock. The marker is hidden when disabled, before the first coordinate, or after HOLD_FRAMES frames without an update.

## Interface
- H_ACT, 640: active pixels per line
- V_ACT, 480: active lines per frame
- SRC_W, 4000: projection-space width
- SRC_H, 2900: projection-space height
- MARK_R, 8: marker half-size in pixels
- MARK_COLOR, 24'hFF0000: marker RGB value
- HOLD_FRAMES, 30: frames a marker persists without a new coordinate
- clk  input  1  single clock for the coordinate and video paths
- rst  input  1  synchronous, active-high reset
- coord_valid  input  1  coordinate present
- coord_ready  output  1  block can accept a coordinate
- x_2d  input  16  projection x
- y_2d  input  16  projection y
- marker_en  input  1  global marker enable
- vs_in, hs_in, de_in  input  1 each  video syncs and data enable
- rgb_in  input  24  pixel data
- vs_out, hs_out, de_out  output  1 each  syncs delayed by 1 clock
- rgb_out  output  24  pixel data with the overlay applied, delayed by 1 clock

## Operation
- **Coordinate FSM states:** IDLE, DIV_X, DIV_Y, DONE. `coord_ready` = (state == IDLE).
- **Accept:** in IDLE, `coord_valid` && `coord_ready` → accept.
  - Clamp: if x_2d ≥ SRC_W, use SRC_W-1; if y_2d ≥ SRC_H, use SRC_H-1. This covers the wrapped 16-bit values the projection produces on underflow.
  - Go to DIV_X.
- **Divide:**
  - DIV_X computes floor(xc·H_ACT / SRC_W).
  - DIV_Y computes floor(yc·V_ACT / SRC_H).
  - Each axis uses a 24-bit dividend and a restoring divider, 1 quotient bit per clock, 24 clocks per axis.
  - Results are clamped to H_ACT-1 / V_ACT-1.
- **DONE (one cycle):** writes `pend_x`, `pend_y` and sets `pend_valid`, then returns to IDLE.
- **Video counters:**
  - `h_cnt` increments on each de_in pixel and clears on de_in falling edge.
  - `v_cnt` increments on de_in falling edge and clears on vs_in rising edge.
- **Frame latch (vs_in rising edge):**
  - If `pend_valid`: copy pend → `mark_x`/`mark_y`, set `mark_valid`, clear `age`, clear `pend_valid`.
  - Otherwise: `age` increments, saturating at HOLD_FRAMES. When `age` reaches HOLD_FRAMES, `mark_valid` clears.
- **Simultaneous DONE write and vs_in rise:**
  - The frame latches the old pend contents, only if `pend_valid` was already 1.
  - The new value stays pending, and `pend_valid` ends at 1.
- **Draw condition:** draw when `marker_en` && `mark_valid` && de_in && dx ≤ MARK_R && dy ≤ MARK_R && (dx ≥ MARK_R-1 || dy ≥ MARK_R-1).
  - dx = |h_cnt - mark_x|, dy = |v_cnt - mark_y|, computed in signed 12-bit arithmetic.
  - The outline is 2 pixels thick and is clipped naturally at screen edges.
- **Output:** rgb_out = draw ? MARK_COLOR : rgb_in.
- **Reset (rst mid-operation):** aborts any division, returns to IDLE, clears `pend_valid`, `mark_valid`, `age` and all counters.

## Timing
- Reset values: vs_out, hs_out, de_out = 0; rgb_out = 0; coord_ready = 1 (during and after reset).
- Accept at edge 0 → DIV_X on edges 1–24, DIV_Y on edges 25–48.
  - `pend_*` are written at edge 49.
  - coord_ready is low after edge 0 and high again after edge 49.
- A coordinate presented while coord_ready = 0 is not accepted; upstream holds it.
- Video path has a fixed latency of 1 clock for all outputs, with no dependence on FSM state.
- A new marker position first appears in the frame whose vs_in rising edge occurs after the `pend_*` write.

## Test plan
- **Nominal position:** x_2d = 2000, y_2d = 1450 → mark_x = 320, mark_y = 240. Next frame: rgb_out = FF0000 at (312, 240) and (328, 240), and at (313, 240) and (327, 240). rgb_in passes through at (320, 240) and at (311, 240).
- **Clamping:** x_2d = 65500, y_2d = 0 → mark_x = 639, mark_y = 0. The marker is clipped at the top-right edge, and no pixel outside the active area is altered.
- **Handshake timing:** assert coord_valid continuously → accepts spaced exactly 50 clocks apart; pend_valid rises at accept + 49.
- **Collision:** DONE write on the same edge as vs_in rise, with pend_valid = 0 beforehand → the current frame shows no update, and the next frame shows the new position.
- **Persistence:** one coordinate, then 30 frames with none → marker visible in frames 1–29 after latch, and absent from the 30th on. marker_en = 0 → rgb_out = rgb_in always.
- **Reset mid-divide:** rst asserted during DIV_Y → coord_ready = 1 next clock, pend_valid = 0, and no marker is drawn.
